// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
//   Holds the fetch PC, looks it up in the BTB, issues one instruction-memory
//   read per cycle while the fetch queue has room, and buffers returned words
//   (with PC and prediction metadata) in a FQ_DEPTH-entry queue toward decode.
//   An EX redirect flushes the queue and any in-flight response.
//
// Configuration macro: FETCH_BTB_EN
//   defined   -> BTB hit/target steer the next PC and the dec_pred_* outputs
//   undefined -> BTB inputs ignored, next PC is always pc+4, never predicted taken
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   fetch_pc / fetch_btb_hit/target   BTB lookup address and same-cycle result
//   imem_req / imem_addr / imem_rdata instruction memory, data one cycle later
//   redirect_valid / redirect_pc      EX-stage redirect
//   dec_valid / dec_ready             queue head handshake toward decode
//   dec_instr / dec_pc / dec_pred_*   queue head contents
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] fetch_pc,
  input  logic        fetch_btb_hit,
  input  logic [31:0] fetch_btb_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        dec_pred_taken,
  output logic [31:0] dec_pred_target
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]         r_pc;
  logic                r_inflight;
  logic [31:0]         r_f1_pc;
  logic                r_f1_taken;
  logic [31:0]         r_f1_tgt;

  logic [31:0]         r_q_instr [FQ_DEPTH];
  logic [31:0]         r_q_pc    [FQ_DEPTH];
  logic [31:0]         r_q_tgt   [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] r_q_taken;
  logic [PW-1:0]       r_head, r_tail;
  logic [CW-1:0]       r_count;

  logic [31:0]         w_pc_plus4;
  logic [31:0]         w_next_pc;
  logic                w_taken;
  logic [CW-1:0]       w_occ;
  logic                w_req;
  logic                w_deq;

  assign w_pc_plus4 = r_pc + 32'd4;

`ifdef FETCH_BTB_EN
  assign w_taken   = fetch_btb_hit;
  assign w_next_pc = fetch_btb_hit ? fetch_btb_target : w_pc_plus4;
`else
  // BTB ports stay on the boundary but carry no meaning in this build.
  logic w_unused_btb;
  assign w_unused_btb = ^{fetch_btb_hit, fetch_btb_target};
  assign w_taken      = 1'b0;
  assign w_next_pc    = w_pc_plus4;
`endif

  // Counting the in-flight response as occupied space means a response can
  // always be enqueued, so the queue never needs to push back on memory.
  assign w_occ = r_count + CW'(r_inflight);
  assign w_req = !rst && !redirect_valid && (w_occ < CW'(FQ_DEPTH));
  assign w_deq = (r_count != '0) && dec_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_f1_pc    <= '0;
      r_f1_taken <= 1'b0;
      r_f1_tgt   <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_q_taken  <= '0;
      // Entries are cleared so the head-driven dec_* outputs read zero after reset.
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
        r_q_tgt[i]   <= '0;
      end
    end else if (redirect_valid) begin
      // Flush wins over everything, including a same-cycle dequeue.
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_pc       <= w_next_pc;
        r_f1_pc    <= r_pc;
        r_f1_taken <= w_taken;
        r_f1_tgt   <= w_next_pc;
      end
      if (r_inflight) begin
        r_q_instr[r_tail] <= imem_rdata;
        r_q_pc[r_tail]    <= r_f1_pc;
        r_q_taken[r_tail] <= r_f1_taken;
        r_q_tgt[r_tail]   <= r_f1_tgt;
        r_tail            <= r_tail + PW'(1);
      end
      if (w_deq) r_head <= r_head + PW'(1);
      r_count <= r_count + CW'(r_inflight) - CW'(w_deq);
    end
  end

  assign fetch_pc        = r_pc;
  assign imem_addr       = r_pc;
  assign imem_req        = w_req;
  assign dec_valid       = (r_count != '0);
  assign dec_instr       = r_q_instr[r_head];
  assign dec_pc          = r_q_pc[r_head];
  assign dec_pred_taken  = r_q_taken[r_head];
  assign dec_pred_target = r_q_tgt[r_head];
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          FQ  = 4;
`ifdef FETCH_BTB_EN
  localparam bit BTB_EN = 1'b1;
`else
  localparam bit BTB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, fetch_btb_hit, redirect_valid, dec_ready;
  logic [31:0] fetch_btb_target, redirect_pc, imem_rdata;
  logic [31:0] fetch_pc, imem_addr, dec_instr, dec_pc, dec_pred_target;
  logic        imem_req, dec_valid, dec_pred_taken;

  fetch_unit #(.RESET_PC(RPC), .FQ_DEPTH(FQ)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_btb_hit(fetch_btb_hit),
    .fetch_btb_target(fetch_btb_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_pred_taken(dec_pred_taken), .dec_pred_target(dec_pred_target));

  always #5 clk = ~clk;

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory answers one cycle after the address is presented.
  always @(posedge clk) imem_rdata <= mem_fn(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        tk;
    logic [31:0] tgt;
  } ent_t;

  // Reference model: delivered-instruction queue, pending response, fetch PC.
  ent_t        mq[$];
  int          pend;
  logic [31:0] p_pc, p_tgt, m_pc;
  logic        p_tk;

  int checks = 0;
  int errors = 0;

  logic        o_req, o_valid, o_taken;
  logic [31:0] o_fetch, o_pc, o_instr, o_tgt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit rv, input logic [31:0] rpc,
                      input bit rdy, input bit hit, input logic [31:0] tgt);
    bit          exp_req, tk;
    logic [31:0] nxt;
    ent_t        e;
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rpc; dec_ready = rdy;
    fetch_btb_hit = hit; fetch_btb_target = tgt;
    #1;
    exp_req = !r && !rv && ((mq.size() + pend) < FQ);
    o_req = imem_req; o_valid = dec_valid; o_fetch = fetch_pc; o_pc = dec_pc;
    o_instr = dec_instr; o_taken = dec_pred_taken; o_tgt = dec_pred_target;
    chk("imem_req", {31'b0, o_req}, {31'b0, exp_req});
    chk("fetch_pc", o_fetch, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("dec_valid", {31'b0, o_valid}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("dec_pc", o_pc, mq[0].pc);
      chk("dec_instr", o_instr, mq[0].instr);
      chk("dec_pred_taken", {31'b0, o_taken}, {31'b0, mq[0].tk});
      chk("dec_pred_target", o_tgt, mq[0].tgt);
    end
    @(posedge clk);
    if (r) begin
      mq.delete(); pend = 0; m_pc = RPC;
    end else if (rv) begin
      mq.delete(); pend = 0; m_pc = rpc;
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (pend != 0) begin
        e.pc = p_pc; e.instr = mem_fn(p_pc); e.tk = p_tk; e.tgt = p_tgt;
        mq.push_back(e);
      end
      tk  = BTB_EN && hit;
      nxt = tk ? tgt : m_pc + 32'd4;
      if (exp_req) begin
        pend = 1; p_pc = m_pc; p_tk = tk; p_tgt = nxt; m_pc = nxt;
      end else pend = 0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, o_valid}, 32'd0);
    chk({tag, "_instr"}, o_instr, 32'd0);
    chk({tag, "_pc"}, o_pc, 32'd0);
    chk({tag, "_taken"}, {31'b0, o_taken}, 32'd0);
    chk({tag, "_tgt"}, o_tgt, 32'd0);
    chk({tag, "_fetch"}, o_fetch, RPC);
  endtask

  initial begin
    int          nreq;
    logic [31:0] nexp;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    fetch_btb_hit = 1'b0; fetch_btb_target = '0;
    pend = 0; m_pc = RPC; p_pc = '0; p_tgt = '0; p_tk = 1'b0;

    // Power-on reset, then sequential fetch with a BTB hit at 0x108.
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, m_pc == 32'h108, 32'h200);
    chk_reset_outputs("por");
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 0, 1, m_pc == 32'h108, 32'h200);
      if (k == 2) begin
        chk("seq_v0", {31'b0, o_valid}, 32'd1);
        chk("seq_pc0", o_pc, 32'h100);
        chk("seq_tk0", {31'b0, o_taken}, 32'd0);
      end
      if (k == 3) begin
        chk("seq_pc1", o_pc, 32'h104);
        chk("btb_next_fetch", o_fetch, BTB_EN ? 32'h200 : 32'h10C);
      end
      if (k == 4) begin
        chk("seq_pc2", o_pc, 32'h108);
        chk("btb_tk", {31'b0, o_taken}, {31'b0, BTB_EN});
        chk("btb_tgt", o_tgt, BTB_EN ? 32'h200 : 32'h10C);
      end
    end

    // Decode stall: exactly FQ issues, then in-order drain.
    step(0, 1, 32'h1000, 0, 0, 0);
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 0, 0, 0);
      if (o_req) nreq++;
    end
    chk("stall_issues", nreq, FQ);
    nexp = 32'h1000;
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, 1, 0, 0);
      if (k == 0) chk("stall_hold_req", {31'b0, o_req}, 32'd0);
      if (k == 1) chk("stall_resume_req", {31'b0, o_req}, 32'd1);
      if (o_valid) begin
        chk("drain_order", o_pc, nexp);
        nexp = nexp + 32'd4;
      end
    end

    // Redirect with three entries queued and one response in flight.
    step(0, 1, 32'h2000, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h400, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("redir_v1", {31'b0, o_valid}, 32'd0);
    chk("redir_fetch", o_fetch, 32'h400);
    chk("redir_req", {31'b0, o_req}, 32'd1);
    step(0, 0, 0, 1, 0, 0);
    chk("redir_v2", {31'b0, o_valid}, 32'd0);
    step(0, 0, 0, 1, 0, 0);
    chk("redir_v3", {31'b0, o_valid}, 32'd1);
    chk("redir_pc3", o_pc, 32'h400);

    // Reset with a full queue.
    step(0, 1, 32'h3000, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 0, 0);
    chk("full_before_rst", {31'b0, o_valid}, 32'd1);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk_reset_outputs("midrst");
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 0);

    // PC wrap, with and without a BTB hit at the top address.
    step(0, 1, 32'hFFFF_FFFC, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("wrap_miss", o_fetch, 32'h0);
    step(0, 1, 32'hFFFF_FFFC, 1, 0, 0);
    step(0, 0, 0, 1, 1, 32'h300);
    step(0, 0, 0, 1, 0, 0);
    chk("wrap_hit", o_fetch, BTB_EN ? 32'h300 : 32'h0);

    // Randomized traffic against the model.
    for (int k = 0; k < 500; k++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 5, $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the core. Holds the architectural fetch PC, drives the branch target buffer lookup and the instruction memory, selects the next PC from the BTB prediction, and buffers fetched instructions in a small queue toward decode with a valid/ready handshake. EX-stage redirects (mispredicts, jumps) flush all fetch state and restart from the corrected PC.

## Interface
- `RESET_PC`, 32'h0000_0000, first PC fetched after reset
- `FQ_DEPTH`, 4, fetch queue entries; power of two, ≥2

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `fetch_pc`  out  32  PC presented to the BTB this cycle (= PC register)
- `fetch_btb_hit`  in  1  BTB hit for `fetch_pc`, same cycle
- `fetch_btb_target`  in  32  predicted target for `fetch_pc`, same cycle
- `imem_req`  out  1  instruction read request this cycle
- `imem_addr`  out  32  read address, always equal to `fetch_pc`
- `imem_rdata`  in  32  instruction word, valid exactly one cycle after an accepted `imem_req`
- `redirect_valid`  in  1  EX redirect
- `redirect_pc`  in  32  redirect target
- `dec_valid`  out  1  queue head valid
- `dec_ready`  in  1  decode accepts head
- `dec_instr`  out  32  head instruction
- `dec_pc`  out  32  head PC
- `dec_pred_taken`  out  1  head was predicted taken
- `dec_pred_target`  out  32  head predicted target (`dec_pc`+4 when not taken)

## Operation
- PC register `pc`; `fetch_pc` = `imem_addr` = `pc`.
- Issue condition: `imem_req` = !`rst` && !`redirect_valid` && (`count` + `inflight`) < `FQ_DEPTH`; `inflight` is 1 if a request was issued last cycle and not cancelled. Guarantees no queue overflow.
- On issue: `pc` ← `fetch_btb_hit` ? `fetch_btb_target` : `pc`+4 (mod 2^32, wraps from 32'hFFFF_FFFC to 0); F1 register captures {`pc`, hit, next PC}.
- No issue: `pc` holds.
- Response cycle: `imem_rdata` plus F1 metadata enqueued at tail.
- Dequeue when `dec_valid` && `dec_ready`; enqueue and dequeue in the same cycle permitted, including at `count`==`FQ_DEPTH`-1 and when full with dequeue.
- `dec_valid` = (`count` != 0); outputs driven from head entry register, no bypass.
- Redirect (highest priority): `pc` ← `redirect_pc`; queue emptied (`count`←0); in-flight response discarded (`inflight`←0); no request that cycle; a simultaneous dequeue is ignored; `dec_valid` drops the next cycle.
- Low two bits of `redirect_pc`/`fetch_btb_target` used as given; no alignment check.

## Timing
- Reset values (cycle after `rst` sampled high): `pc`=`RESET_PC`, `count`=0, `inflight`=0, `dec_valid`=0, `dec_instr`/`dec_pc`/`dec_pred_target`=0, `dec_pred_taken`=0; `imem_req`=0 while `rst` is high.
- `rst` mid-operation: identical to power-on reset; pending responses discarded.
- Latency: request at cycle N → entry enqueued at edge ending N+1 → `dec_valid` at N+2 (empty queue).
- Redirect at cycle N → first request to `redirect_pc` at N+1 → `dec_valid` at N+3.
- Sustained throughput one instruction/cycle when `dec_ready` held high.
- Stall: `dec_ready` low → queue fills; `imem_req` deasserts once `count`+`inflight` = `FQ_DEPTH`; resumes the cycle after the first dequeue frees space.

## Configuration
- `FETCH_BTB_EN` defined: next PC and `dec_pred_*` use the BTB as described.
- Undefined: `fetch_btb_hit`/`fetch_btb_target` ignored; next PC always `pc`+4; `dec_pred_taken`=0; `dec_pred_target`=`dec_pc`+4. Ports remain present.

## Test plan
- Reset, `RESET_PC`=32'h100, BTB misses, `dec_ready`=1 → `dec_pc` sequence 100,104,108 one per cycle from cycle 2; `dec_pred_taken`=0.
- BTB hit at PC 32'h108, target 32'h200 → next `fetch_pc` 200; entry for 108 has `dec_pred_taken`=1, `dec_pred_target`=200.
- `dec_ready`=0 for 10 cycles → exactly 4 entries queued, `imem_req` low after 4 issues; release → PCs delivered in order, none lost or duplicated.
- Redirect to 32'h400 while queue holds 3 entries and a response is in flight → `dec_valid`=0 next cycle, first delivered `dec_pc`=400 at redirect+3.
- `rst` asserted with full queue → all outputs at reset values next cycle, fetch restarts at `RESET_PC`.
- PC 32'hFFFF_FFFC, miss → next `fetch_pc`=0; with `FETCH_BTB_EN` undefined, hit input ignored.
